// File: rtl/shift_reg_piso_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_pkg
// Shared types and helpers for the shift_reg_piso block.
//   state_t   : frame sequencer states (IDLE, SHIFT, DONE)
//   cnt_width : width of a counter that must hold the values 0..width
// -----------------------------------------------------------------------------
package shift_reg_piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The bit counter has to reach WIDTH itself (not just WIDTH-1).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_piso_lane.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_lane
// One serial lane: WIDTH-bit shift register, direction mux, serial output and
// an optional capture register holding the word shifted in during a frame.
//
// Optional feature macro: SHIFT_REG_PISO_CAPTURE_EN
//   defined   : cap holds the post-shift register contents of the final frame
//               shift (the WIDTH serial-in bits of that frame)
//   undefined : cap is constant 0 and no capture register exists
//
// Ports
//   clk      in   clock, rising edge
//   clr      in   synchronous clear of sr and cap (highest priority)
//   load     in   parallel load sr <= d
//   shift    in   shift one position, ds enters at the far end
//   capture  in   final shift of a frame; only asserted together with shift
//   d        in   parallel data for this lane
//   ds       in   serial data in
//   q        out  serial data out
//   q_n      out  complement of q
//   cap      out  captured serial-in word
// -----------------------------------------------------------------------------
module shift_reg_piso_lane
  import shift_reg_piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             capture,
  input  logic [WIDTH-1:0] d,
  input  logic             ds,
  output logic             q,
  output logic             q_n,
  output logic [WIDTH-1:0] cap
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;

  // Direction is fixed at elaboration; the output bit is always the end the
  // data moves toward, and ds always enters at the opposite end.
  if (MSB_FIRST) begin : g_msb_first
    assign sr_shifted = {sr[WIDTH-2:0], ds};
    assign q          = sr[WIDTH-1];
  end else begin : g_lsb_first
    assign sr_shifted = {ds, sr[WIDTH-1:1]};
    assign q          = sr[0];
  end

  assign q_n = ~q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= sr_shifted;
    end
  end

`ifdef SHIFT_REG_PISO_CAPTURE_EN
  logic [WIDTH-1:0] cap_r;

  // Captures the value sr takes on the same edge, so cap equals the new sr
  // right as DONE rises.
  always_ff @(posedge clk) begin
    if (clr) begin
      cap_r <= '0;
    end else if (capture) begin
      cap_r <= sr_shifted;
    end
  end

  assign cap = cap_r;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap            = '0;
`endif

endmodule

// File: rtl/shift_reg_piso.sv
// -----------------------------------------------------------------------------
// shift_reg_piso
// Parallel-in/serial-out shift register bank of CHAINS lanes sharing one frame
// sequencer. A frame loads D, shifts WIDTH bits out (stalling while CE_n is
// high) and ends with a one-cycle DONE pulse. Manual load/shift is available
// while idle.
//
// Optional feature macro: SHIFT_REG_PISO_CAPTURE_EN (capture of the serial-in
// word at frame end onto CAP; CAP is constant 0 when undefined).
//
// Handshake: START is a request that is only accepted in IDLE, on the edge it
// is sampled high; BUSY rises on that edge and stays high through the DONE
// cycle; DONE is a single-cycle completion pulse; no new request is accepted
// while BUSY is high, and START held high starts the next frame on the edge
// after DONE falls.
//
// Ports
//   CP         in   clock, rising edge
//   MR         in   synchronous active-high reset, aborts any frame
//   D          in   parallel data, lane k = D[k*WIDTH +: WIDTH]
//   DS         in   serial data in, one bit per lane
//   PL         in   manual parallel load (IDLE only)
//   CE_n       in   active-low shift enable (manual shift / frame stall)
//   START      in   frame request
//   Q          out  serial out per lane
//   Q_n        out  complement of Q
//   BUSY       out  frame in progress (SHIFT or DONE)
//   DONE       out  frame-complete pulse
//   CAP        out  captured serial-in word per lane
//   state_dbg  out  current sequencer state
// -----------------------------------------------------------------------------
module shift_reg_piso
  import shift_reg_piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHAINS    = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     CP,
  input  logic                     MR,
  input  logic [CHAINS*WIDTH-1:0]  D,
  input  logic [CHAINS-1:0]        DS,
  input  logic                     PL,
  input  logic                     CE_n,
  input  logic                     START,
  output logic [CHAINS-1:0]        Q,
  output logic [CHAINS-1:0]        Q_n,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [CHAINS*WIDTH-1:0]  CAP,
  output state_t                   state_dbg
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // The DONE port shadows the package's DONE literal, so states are named
  // through local aliases.
  localparam state_t ST_IDLE  = shift_reg_piso_pkg::IDLE;
  localparam state_t ST_SHIFT = shift_reg_piso_pkg::SHIFT;
  localparam state_t ST_DONE  = shift_reg_piso_pkg::DONE;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          busy_r;
  logic          done_r;

  logic          do_load;
  logic          do_shift;
  logic          do_capture;

  // Sequencer: state, bit counter and the registered BUSY/DONE flags.
  always_ff @(posedge CP) begin
    if (MR) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state  <= ST_SHIFT;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!CE_n) begin
            cnt <= cnt + CW'(1);
            // cnt still holds the pre-shift count: this is the WIDTH-th shift.
            if (cnt == LAST) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Shared lane strobes. In IDLE the priority is START > PL > CE_n, and START
  // and PL both load. DONE ignores every control input.
  always_comb begin
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START || PL) begin
          do_load = 1'b1;
        end else if (!CE_n) begin
          do_shift = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!CE_n) begin
          do_shift   = 1'b1;
          do_capture = (cnt == LAST);
        end
      end
      default: begin
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_capture = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < CHAINS; k++) begin : g_lane
    shift_reg_piso_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk     (CP),
      .clr     (MR),
      .load    (do_load),
      .shift   (do_shift),
      .capture (do_capture),
      .d       (D[k*WIDTH +: WIDTH]),
      .ds      (DS[k]),
      .q       (Q[k]),
      .q_n     (Q_n[k]),
      .cap     (CAP[k*WIDTH +: WIDTH])
    );
  end

  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_reg_piso.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_piso
// Two instances share the control inputs: an MSB-first bank of two lanes and
// an LSB-first single lane. The reference model keeps every lane as a queue
// of bits in output order (front = Q) plus a frame flag and a shift count.
// -----------------------------------------------------------------------------
module tb_shift_reg_piso;

  localparam int W = 8;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        cp = 1'b0;
  logic        mr, pl, ce_n, start;
  logic [15:0] d_m;
  logic [1:0]  ds_m;
  logic [7:0]  d_l;
  logic [0:0]  ds_l;

  logic [1:0]  q_m, qn_m;
  logic        busy_m, done_m;
  logic [15:0] cap_m;
  logic [0:0]  q_l, qn_l;
  logic        busy_l, done_l;
  logic [7:0]  cap_l;
  shift_reg_piso_pkg::state_t st_m, st_l;

  always #5 cp = ~cp;

  shift_reg_piso #(.WIDTH(W), .CHAINS(2), .MSB_FIRST(1'b1)) u_dut_m (
    .CP(cp), .MR(mr), .D(d_m), .DS(ds_m), .PL(pl), .CE_n(ce_n), .START(start),
    .Q(q_m), .Q_n(qn_m), .BUSY(busy_m), .DONE(done_m), .CAP(cap_m),
    .state_dbg(st_m)
  );

  shift_reg_piso #(.WIDTH(W), .CHAINS(1), .MSB_FIRST(1'b0)) u_dut_l (
    .CP(cp), .MR(mr), .D(d_l), .DS(ds_l), .PL(pl), .CE_n(ce_n), .START(start),
    .Q(q_l), .Q_n(qn_l), .BUSY(busy_l), .DONE(done_l), .CAP(cap_l),
    .state_dbg(st_l)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Lanes 0,1: MSB-first instance; lane 2: LSB-first instance.
  bit         lq[3][$];
  logic [7:0] m_cap[3];
  bit         m_frame;
  bit         m_done;
  int         m_shifts;

  function automatic logic [7:0] lane_d(input int k);
    if (k == 0) return d_m[7:0];
    if (k == 1) return d_m[15:8];
    return d_l;
  endfunction

  function automatic bit lane_ds(input int k);
    if (k < 2) return ds_m[k];
    return ds_l[0];
  endfunction

  // Bits leave an MSB-first lane from the top of the word, LSB-first from bit 0.
  task automatic m_load();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] w;
      w = lane_d(k);
      lq[k].delete();
      for (int i = 0; i < W; i++) lq[k].push_back((k < 2) ? w[W-1-i] : w[i]);
    end
  endtask

  task automatic m_shift();
    for (int k = 0; k < 3; k++) begin
      void'(lq[k].pop_front());
      lq[k].push_back(lane_ds(k));
    end
  endtask

  function automatic logic [7:0] m_word(input int k);
    logic [7:0] w;
    for (int i = 0; i < W; i++) begin
      if (k < 2) w[W-1-i] = lq[k][i];
      else       w[i]     = lq[k][i];
    end
    return w;
  endfunction

  task automatic model_step();
    if (mr) begin
      for (int k = 0; k < 3; k++) begin
        lq[k].delete();
        for (int i = 0; i < W; i++) lq[k].push_back(1'b0);
        m_cap[k] = 8'h00;
      end
      m_frame = 0; m_done = 0; m_shifts = 0;
    end else if (m_done) begin
      m_done = 0; m_frame = 0;
    end else if (m_frame) begin
      if (!ce_n) begin
        m_shift();
        m_shifts++;
        if (m_shifts == W) begin
          m_done = 1;
`ifdef SHIFT_REG_PISO_CAPTURE_EN
          for (int k = 0; k < 3; k++) m_cap[k] = m_word(k);
`endif
        end
      end
    end else if (start) begin
      m_load();
      m_frame = 1; m_shifts = 0;
    end else if (pl) begin
      m_load();
    end else if (!ce_n) begin
      m_shift();
    end
  endtask

  function automatic logic [1:0] exp_qm();
    return {lq[1][0], lq[0][0]};
  endfunction

  function automatic logic [15:0] exp_capm();
    return {m_cap[1], m_cap[0]};
  endfunction

  // One clock: model follows the same sampled inputs, outputs settle by #1.
  task automatic tick();
    @(posedge cp);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mr = 1; pl = 0; ce_n = 1; start = 0;
    d_m = '0; ds_m = '0; d_l = '0; ds_l = '0;
    tick(); tick();
    checks++; if (q_m !== 2'b00)   begin errors++; $display("FAIL reset_q got %b expected 00", q_m); end
    checks++; if (qn_m !== 2'b11)  begin errors++; $display("FAIL reset_qn got %b expected 11", qn_m); end
    checks++; if (q_l !== 1'b0 || qn_l !== 1'b1) begin errors++; $display("FAIL reset_lsb got q=%b qn=%b expected 0/1", q_l, qn_l); end
    checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b expected 0/0", busy_m, done_m); end
    checks++; if (cap_m !== 16'h0 || cap_l !== 8'h0) begin errors++; $display("FAIL reset_cap got %h/%h expected 0", cap_m, cap_l); end
    checks++; if (st_m !== shift_reg_piso_pkg::IDLE) begin errors++; $display("FAIL reset_state got %0d expected IDLE", st_m); end
    mr = 0;

    // Abort a frame with a two-cycle reset sampled at edges 4 and 5.
    d_m = 16'($urandom); d_l = 8'($urandom); ds_m = 2'b11; ds_l = 1'b1;
    start = 1; ce_n = 0;
    tick();
    start = 0;
    tick(); tick();
    mr = 1;
    for (int e = 4; e <= 5; e++) begin
      tick();
      checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL midreset_done edge %0d got %b expected 0", e, done_m); end
    end
    checks++; if (q_m !== 2'b00 || qn_m !== 2'b11) begin errors++; $display("FAIL midreset_q got q=%b qn=%b expected 00/11", q_m, qn_m); end
    checks++; if (busy_m !== 1'b0 || busy_l !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b/%b expected 0", busy_m, busy_l); end
    checks++; if (cap_m !== 16'h0 || cap_l !== 8'h0) begin errors++; $display("FAIL midreset_cap got %h/%h expected 0", cap_m, cap_l); end
    mr = 0; ce_n = 1;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++; if (done_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL after_abort cycle %0d got done=%b busy=%b expected 0/0", e, done_m, busy_m); end
    end
  endtask

  task automatic test_frame_capture();
    logic [7:0] pat;
    logic [7:0] seq0;
    logic [7:0] seq1;
    pat = 8'h5A; seq0 = 8'hA5; seq1 = 8'h3C;
    d_m = {8'h3C, 8'hA5}; d_l = 8'hA5; ds_l = 1'b1;
    start = 1; ce_n = 0;
    for (int e = 1; e <= 11; e++) begin
      // The shift on edge e (2..9) takes serial bit e-2 of the pattern.
      ds_m[0] = (e >= 2 && e <= 9) ? pat[W-1-(e-2)] : 1'b0;
      ds_m[1] = 1'($urandom);
      tick();
      start = 0;
      if (e <= 8) begin
        checks++; if (q_m !== {seq1[W-e], seq0[W-e]}) begin errors++; $display("FAIL frame_q_msb edge %0d got %b expected %b", e, q_m, {seq1[W-e], seq0[W-e]}); end
        checks++; if (q_l[0] !== seq0[e-1]) begin errors++; $display("FAIL frame_q_lsb edge %0d got %b expected %b", e, q_l, seq0[e-1]); end
      end
      checks++; if (q_m !== exp_qm() || qn_m !== ~exp_qm()) begin errors++; $display("FAIL frame_model edge %0d got q=%b qn=%b expected %b", e, q_m, qn_m, exp_qm()); end
      checks++; if (done_m !== (e == 9) || done_l !== (e == 9)) begin errors++; $display("FAIL frame_done edge %0d got %b/%b expected %b", e, done_m, done_l, (e == 9)); end
      checks++; if (busy_m !== (e <= 9)) begin errors++; $display("FAIL frame_busy edge %0d got %b expected %b", e, busy_m, (e <= 9)); end
      if (e == 9) begin
`ifdef SHIFT_REG_PISO_CAPTURE_EN
        checks++; if (cap_m[7:0] !== 8'h5A || cap_l !== 8'hFF) begin errors++; $display("FAIL capture got %h/%h expected 5a/ff", cap_m[7:0], cap_l); end
`else
        checks++; if (cap_m !== 16'h0 || cap_l !== 8'h0) begin errors++; $display("FAIL capture_off got %h/%h expected 0", cap_m, cap_l); end
`endif
      end
      // Edge 11 is a manual idle shift: CAP must not move.
      checks++; if (cap_m !== exp_capm() || cap_l !== m_cap[2]) begin errors++; $display("FAIL cap_hold edge %0d got %h/%h expected %h/%h", e, cap_m, cap_l, exp_capm(), m_cap[2]); end
    end
    ce_n = 1;
  endtask

  task automatic test_stall();
    d_m = 16'($urandom); d_l = 8'($urandom);
    start = 1; ce_n = 0;
    for (int e = 1; e <= 13; e++) begin
      ce_n = (e >= 5 && e <= 7);
      ds_m = 2'($urandom); ds_l = 1'($urandom);
      tick();
      start = 0;
      if (e >= 4 && e <= 7) begin
        checks++; if (q_m !== {d_m[12], d_m[4]}) begin errors++; $display("FAIL stall_hold edge %0d got %b expected %b", e, q_m, {d_m[12], d_m[4]}); end
      end
      checks++; if (q_m !== exp_qm() || q_l[0] !== lq[2][0]) begin errors++; $display("FAIL stall_model edge %0d got %b/%b expected %b/%b", e, q_m, q_l, exp_qm(), lq[2][0]); end
      checks++; if (done_m !== (e == 12)) begin errors++; $display("FAIL stall_done edge %0d got %b expected %b", e, done_m, (e == 12)); end
    end
    ce_n = 1;
  endtask

  task automatic test_back_to_back();
    start = 1; ce_n = 0;
    for (int e = 1; e <= 20; e++) begin
      d_m = 16'($urandom); d_l = 8'($urandom); ds_m = 2'($urandom); ds_l = 1'($urandom);
      tick();
      checks++; if (done_m !== (e == 9 || e == 19)) begin errors++; $display("FAIL b2b_done edge %0d got %b expected %b", e, done_m, (e == 9 || e == 19)); end
      checks++; if (busy_m !== (e != 10 && e != 20)) begin errors++; $display("FAIL b2b_busy edge %0d got %b expected %b", e, busy_m, (e != 10 && e != 20)); end
      checks++; if (q_m !== exp_qm()) begin errors++; $display("FAIL b2b_q edge %0d got %b expected %b", e, q_m, exp_qm()); end
    end
    start = 0; ce_n = 1;
  endtask

  task automatic test_priority_manual();
    logic [7:0] want;
    d_m = 16'($urandom); d_l = 8'($urandom);
    start = 1; pl = 1; ce_n = 1;
    tick();
    start = 0; pl = 0;
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL prio_busy got %b expected 1", busy_m); end
    checks++; if (q_m !== exp_qm()) begin errors++; $display("FAIL prio_load got %b expected %b", q_m, exp_qm()); end
    ce_n = 0;
    for (int e = 2; e <= 10; e++) begin
      pl = (e == 3 || e == 4);
      d_m = 16'($urandom); d_l = 8'($urandom); ds_m = 2'($urandom); ds_l = 1'($urandom);
      tick();
      checks++; if (q_m !== exp_qm() || q_l[0] !== lq[2][0]) begin errors++; $display("FAIL pl_ignored edge %0d got %b/%b expected %b/%b", e, q_m, q_l, exp_qm(), lq[2][0]); end
    end
    pl = 0; ce_n = 1;
    tick();
    // Manual load of 81 then one shift with DS=0 leaves 02 in lane 0.
    d_m = {8'($urandom), 8'h81}; d_l = 8'h81; pl = 1;
    tick();
    pl = 0;
    checks++; if (q_m[0] !== 1'b1) begin errors++; $display("FAIL manual_pl got %b expected 1", q_m[0]); end
    ds_m = 2'b00; ds_l = 1'b0; ce_n = 0;
    want = 8'h02;
    for (int i = 0; i < W; i++) begin
      tick();
      checks++; if (q_m[0] !== want[W-1-i]) begin errors++; $display("FAIL manual_shift bit %0d got %b expected %b", i, q_m[0], want[W-1-i]); end
      checks++; if (q_l[0] !== lq[2][0] || busy_m !== 1'b0) begin errors++; $display("FAIL manual_lsb bit %0d got q=%b busy=%b expected %b/0", i, q_l, busy_m, lq[2][0]); end
    end
    ce_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      mr    = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 99) < 10);
      pl    = ($urandom_range(0, 99) < 10);
      ce_n  = ($urandom_range(0, 99) < 35);
      d_m = 16'($urandom); d_l = 8'($urandom); ds_m = 2'($urandom); ds_l = 1'($urandom);
      tick();
      checks++;
      if (q_m !== exp_qm() || qn_m !== ~exp_qm() || q_l[0] !== lq[2][0] || qn_l[0] !== ~lq[2][0]) begin
        errors++; $display("FAIL rand_q cycle %0d got %b/%b expected %b/%b", c, q_m, q_l, exp_qm(), lq[2][0]);
      end
      checks++;
      if (busy_m !== m_frame || done_m !== m_done || busy_l !== m_frame || done_l !== m_done) begin
        errors++; $display("FAIL rand_flags cycle %0d got busy=%b done=%b expected %b/%b", c, busy_m, done_m, m_frame, m_done);
      end
      checks++;
      if (cap_m !== exp_capm() || cap_l !== m_cap[2]) begin
        errors++; $display("FAIL rand_cap cycle %0d got %h/%h expected %h/%h", c, cap_m, cap_l, exp_capm(), m_cap[2]);
      end
    end
    mr = 0; start = 0; pl = 0; ce_n = 1;
  endtask

  initial begin
    mr = 1; pl = 0; ce_n = 1; start = 0;
    d_m = '0; ds_m = '0; d_l = '0; ds_l = '0;
    m_frame = 0; m_done = 0; m_shifts = 0;
    test_reset();
    test_frame_capture();
    test_stall();
    test_back_to_back();
    test_priority_manual();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
